llbit_monitor: RTL
==================

// Module: llbit_monitor
// PURPOSE
//  Multi-channel LL/SC reservation monitor, replacing the single-bit LLbit register.
//  Each channel (hart/thread) holds one reservation: a valid bit, a granule address tag and an age counter.
//  A reservation is cleared by: SC, exception, CSR clear, a conflicting store from another channel, or timeout.
//  Sits beside the MEM stage; SC success is returned one cycle after the SC request.
// PARAMETERS
//  NUM_CH     2    number of channels, 1..8
//  ADDR_W     32   physical address width
//  GRAN_BITS  4    low address bits ignored in tag compare (16 B granule); 0 = exact match
//  TIMEOUT    1024 cycles a reservation lives after LL; 0 = no timeout
// PORTS
//  clk        in   1               clock; all state updates on the rising edge
//  rst_n      in   1               synchronous, active-low reset
//  ll_en      in   NUM_CH          per-channel LL commit
//  ll_addr    in   NUM_CH*ADDR_W   LL address, channel c at [c*ADDR_W +: ADDR_W]
//  sc_en      in   NUM_CH          per-channel SC commit
//  sc_addr    in   NUM_CH*ADDR_W   SC address, same packing as ll_addr
//  excp       in   NUM_CH          exception/ERTN flush on the channel; clears its reservation
//  clr        in   NUM_CH          CSR LLBCTL.WCLLB write; clears the channel's reservation
//  snp_en     in   1               committed store from some channel
//  snp_ch     in   max(1,$clog2(NUM_CH))  channel that issued the store
//  snp_addr   in   ADDR_W          store address
//  sc_vld_o   out  NUM_CH          registered; pulses high for 1 cycle, one cycle after sc_en
//  sc_ok_o    out  NUM_CH          registered; SC result, meaningful only when sc_vld_o is high
//  llbit_o    out  NUM_CH          registered; current reservation valid bit (for the CSR read path)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clock edge): all valid bits, tags, counters, sc_vld_o, sc_ok_o and llbit_o go to 0.
//  - Tag match: addr[ADDR_W-1:GRAN_BITS] is equal between the two addresses.
//  - Snoop hit on channel c:
//      snp_en=1, snp_ch!=c, valid[c]=1 and snp_addr matches tag[c].
//      A channel's own stores never clear its own reservation.
//  - Per-channel next-state priority at each edge, highest first:
//      1 excp[c] | clr[c] -> valid=0; if sc_en[c] also asserts: sc_vld=1, sc_ok=0
//      2 sc_en[c]         -> sc_vld=1; sc_ok = valid & tag match(sc_addr) & !snoop hit; valid=0
//                            ll_en on the same cycle is ignored.
//      3 ll_en[c]         -> valid=1, tag=ll_addr, age=0
//                            LL overrides a same-cycle snoop hit and timeout; the store is ordered first.
//      4 snoop hit        -> valid=0
//      5 timeout          -> valid=0 when TIMEOUT!=0 and age==TIMEOUT-1
//      6 otherwise        -> hold; age increments while valid, saturating at TIMEOUT-1
//  - Latency:
//      SC issued at edge N appears on sc_vld_o/sc_ok_o after edge N+1.
//      llbit_o reflects valid, registered, so it updates at the same edge as valid.
//  - Age counter:
//      Width is $clog2(TIMEOUT+1); when TIMEOUT=0 the counter is absent (constant 0).
//      With no other events, llbit_o is high for exactly TIMEOUT cycles after the LL edge.
//  - Channels are independent; one snoop may clear any number of other channels in the same cycle.
//  - snp_ch >= NUM_CH: treated as an external agent and may clear every channel.
//  - sc_en without a prior LL: sc_ok=0.
//  - Back-to-back LL: the reservation is re-armed; tag and age are replaced.
//  - Reset while a reservation is pending: state clears and no sc_vld_o pulse is produced.
// TESTING
//  1 LL ch0 @0x1000, 5 idle cycles, SC ch0 @0x1008 (GRAN_BITS=4)
//      -> next cycle sc_vld_o[0]=1, sc_ok_o[0]=1; then llbit_o[0]=0.
//  2 LL ch0 @0x1000; snoop ch1 @0x100C; SC ch0 @0x1000 -> sc_ok_o[0]=0.
//    Repeat with snp_ch=0 -> sc_ok_o[0]=1.
//  3 LL ch1 @0x2000, then excp[1] in the same cycle as sc_en[1] -> sc_vld_o[1]=1, sc_ok_o[1]=0, llbit_o[1]=0.
//  4 TIMEOUT=8: LL ch0 at edge 0 -> llbit_o[0] high for 8 cycles, low after edge 8.
//    An SC at edge 9 -> sc_ok_o=0.
//  5 Same cycle: ll_en[0] @0x3000 and a snoop ch1 @0x3000 -> llbit_o[0]=1.
//    A later SC @0x3000 -> sc_ok_o[0]=1.
//  6 LL on both channels @0x4000/0x5000, rst_n=0 for 1 cycle -> all outputs 0.
//    SC on both -> sc_ok_o=2'b00.

Source files
------------

// File: rtl/llbit_monitor.sv
// Multi-channel LL/SC reservation monitor.
// Each channel keeps one reservation (valid, granule tag, age).
// SC results are returned one cycle after the SC commit.

module llbit_ch #(
    parameter int CH        = 0,
    parameter int ADDR_W    = 32,
    parameter int GRAN_BITS = 4,
    parameter int TIMEOUT   = 1024,
    parameter int SNP_W     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ll_en,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_en,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic              excp,
    input  logic              clr,
    input  logic              snp_en,
    input  logic [SNP_W-1:0]  snp_ch,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              sc_vld,
    output logic              sc_ok,
    output logic              llbit
);
    localparam int TAG_W = ADDR_W - GRAN_BITS;
    // A zero-timeout build keeps a 1-bit counter that never moves.
    localparam int AGE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TAG_W-1:0] tag;
    logic [AGE_W-1:0] age;
    logic             valid;
    logic             sc_match;
    logic             snp_hit;
    logic             timeout;

    assign sc_match = (sc_addr[ADDR_W-1:GRAN_BITS] == tag);
    // Own stores never kill the reservation; an out-of-range id is an external agent.
    assign snp_hit  = snp_en && (snp_ch != SNP_W'(CH)) && valid &&
                      (snp_addr[ADDR_W-1:GRAN_BITS] == tag);
    assign timeout  = (TIMEOUT != 0) && valid && (age == AGE_MAX);
    assign llbit    = valid;

    // Granule offset bits take no part in the tag compare.
    generate
        if (GRAN_BITS > 0) begin : g_gran
            logic unused_gran;
            assign unused_gran = ^{ll_addr[GRAN_BITS-1:0], sc_addr[GRAN_BITS-1:0],
                                   snp_addr[GRAN_BITS-1:0]};
        end
    endgenerate

    // Reservation update in priority order: kill, SC, LL, snoop, timeout, age.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag    <= '0;
            age    <= '0;
            sc_vld <= 1'b0;
            sc_ok  <= 1'b0;
        end else begin
            sc_vld <= sc_en;
            sc_ok  <= 1'b0;
            if (excp || clr) begin
                valid <= 1'b0;
            end else if (sc_en) begin
                sc_ok <= valid && sc_match && !snp_hit;
                valid <= 1'b0;
            end else if (ll_en) begin
                valid <= 1'b1;
                tag   <= ll_addr[ADDR_W-1:GRAN_BITS];
                age   <= '0;
            end else if (snp_hit || timeout) begin
                valid <= 1'b0;
            end else if (valid && (TIMEOUT != 0) && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end
endmodule

module llbit_monitor #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int GRAN_BITS = 4,
    parameter int TIMEOUT   = 1024,
    parameter int SNP_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ll_en,
    input  logic [NUM_CH*ADDR_W-1:0] ll_addr,
    input  logic [NUM_CH-1:0]        sc_en,
    input  logic [NUM_CH*ADDR_W-1:0] sc_addr,
    input  logic [NUM_CH-1:0]        excp,
    input  logic [NUM_CH-1:0]        clr,
    input  logic                     snp_en,
    input  logic [SNP_W-1:0]         snp_ch,
    input  logic [ADDR_W-1:0]        snp_addr,
    output logic [NUM_CH-1:0]        sc_vld_o,
    output logic [NUM_CH-1:0]        sc_ok_o,
    output logic [NUM_CH-1:0]        llbit_o
);
    // One independent reservation slice per channel; the snoop fans out to all.
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            llbit_ch #(
                .CH        (c),
                .ADDR_W    (ADDR_W),
                .GRAN_BITS (GRAN_BITS),
                .TIMEOUT   (TIMEOUT),
                .SNP_W     (SNP_W)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .ll_en    (ll_en[c]),
                .ll_addr  (ll_addr[c*ADDR_W +: ADDR_W]),
                .sc_en    (sc_en[c]),
                .sc_addr  (sc_addr[c*ADDR_W +: ADDR_W]),
                .excp     (excp[c]),
                .clr      (clr[c]),
                .snp_en   (snp_en),
                .snp_ch   (snp_ch),
                .snp_addr (snp_addr),
                .sc_vld   (sc_vld_o[c]),
                .sc_ok    (sc_ok_o[c]),
                .llbit    (llbit_o[c])
            );
        end
    endgenerate
endmodule
